// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared encodings for the store path
package store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  // Same encoding as the immediate extender so ext_op can be shared
  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ALIGN   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_REQ  = 1'b1;

endpackage

// File: rtl/store_lane_align.sv
// rtl/store_lane_align.sv - combinational lane placement, byte enables and truncation check
module store_lane_align
  import store_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic        ext_op,
  output logic [31:0] lane_data,
  output logic [3:0]  be,
  output logic        misalign,
  output logic        ovf
);

  logic byte_ovf;
  logic half_ovf;

  // Overflow means re-extending the truncated value would not give wdata back
  always_comb begin
    byte_ovf = 1'b0;
    half_ovf = 1'b0;
    if (ext_op == EXT_SIGN) begin
      byte_ovf = (wdata[31:8]  != {24{wdata[7]}});
      half_ovf = (wdata[31:16] != {16{wdata[15]}});
    end else begin
      byte_ovf = |wdata[31:8];
      half_ovf = |wdata[31:16];
    end
  end

  always_comb begin
    lane_data = wdata;
    be        = 4'b0000;
    misalign  = 1'b0;
    ovf       = 1'b0;
    case (size)
      SZ_BYTE: begin
        lane_data = {4{wdata[7:0]}};
        be        = 4'b0001 << addr;
        ovf       = byte_ovf;
      end
      SZ_HALF: begin
        lane_data = {2{wdata[15:0]}};
        be        = addr[1] ? 4'b1100 : 4'b0011;
        misalign  = addr[0];
        ovf       = half_ovf;
      end
      SZ_WORD: begin
        lane_data = wdata;
        be        = 4'b1111;
        misalign  = |addr;
      end
      default: begin
        misalign  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - MEM-stage store FSM with ready handshake and timeout
module store_unit
  import store_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        ext_op,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic        ovf
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic          state;
  logic [CW-1:0] cnt;
  logic          ovf_q;

  logic [31:0] la_data;
  logic [3:0]  la_be;
  logic        la_misalign;
  logic        la_ovf;

  store_lane_align u_align (
    .addr      (addr[1:0]),
    .size      (size),
    .wdata     (wdata),
    .ext_op    (ext_op),
    .lane_data (la_data),
    .be        (la_be),
    .misalign  (la_misalign),
    .ovf       (la_ovf)
  );

  assign mem_we = (state == S_REQ);
  assign busy   = (state == S_REQ);

  // done/err/ovf default low every cycle so they only ever pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ovf_q     <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'd0;
      done      <= 1'b0;
      err       <= ERR_NONE;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= ERR_NONE;
      ovf  <= 1'b0;
      if (state == S_REQ) begin
        if (mem_ready) begin
          state <= S_IDLE;
          done  <= 1'b1;
          ovf   <= ovf_q;
        end else if (cnt == CNT_LAST) begin
          state <= S_IDLE;
          done  <= 1'b1;
          err   <= ERR_TIMEOUT;
          ovf   <= ovf_q;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (start) begin
        mem_addr  <= {addr[31:2], 2'b00};
        mem_wdata <= la_data;
        mem_be    <= la_be;
        ovf_q     <= la_ovf;
        cnt       <= '0;
        if (la_misalign) begin
          done <= 1'b1;
          err  <= ERR_ALIGN;
          ovf  <= la_ovf;
        end else begin
          state <= S_REQ;
        end
      end
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - self-checking bench for store_unit
module tb_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        ext_op;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        ext;
    int          ready_at;
    logic [3:0]  be;
    logic [31:0] data;
    logic [1:0]  err;
    logic        ovf;
  } vec_t;

  vec_t tbl[12];

  store_unit #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .addr      (addr),
    .wdata     (wdata),
    .size      (size),
    .ext_op    (ext_op),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: byte-count arithmetic, truncate then re-extend and compare
  task automatic model(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                       input logic ext, output logic [3:0] be, output logic [31:0] data,
                       output logic mis, output logic ov);
    longint unsigned nb, mask, trunc, re;
    be = 4'd0; data = 32'd0; mis = 1'b1; ov = 1'b0;
    if (sz != 2'd3) begin
      nb   = longint'(1) << sz;
      mis  = (a % nb) != 0;
      be   = 4'(((longint'(1) << nb) - 1) << (a % 4));
      for (int i = 0; i < 4; i++) data[8*i +: 8] = wd[8*(i % int'(nb)) +: 8];
      if (nb < 4) begin
        mask  = (longint'(1) << (8 * nb)) - 1;
        trunc = longint'(wd) & mask;
        re    = trunc;
        if (ext && ((trunc >> (8 * nb - 1)) & 1) == 1) re = trunc | (64'hFFFF_FFFF & ~mask);
        ov = (re != longint'(wd));
      end
    end
  endtask

  task automatic run_cmd(input vec_t v, input string nm);
    int cyc, we_cnt, exp_we, exp_lat;
    logic got, stray;
    case (v.err)
      2'd1:    begin exp_we = 0;        exp_lat = 1; end
      2'd2:    begin exp_we = TO;       exp_lat = TO + 1; end
      default: begin exp_we = v.ready_at; exp_lat = v.ready_at + 1; end
    endcase
    @(negedge clk);
    addr = v.addr; size = v.size; wdata = v.wdata; ext_op = v.ext;
    start = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; we_cnt = 0; got = 1'b0; stray = 1'b0;
    while (cyc <= 20) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (err != 2'd0 || ovf != 1'b0) stray = 1'b1;
      if (mem_we) begin
        we_cnt++;
        if (we_cnt == 1) begin
          chk({nm, " mem_addr"},  mem_addr, {v.addr[31:2], 2'b00});
          chk({nm, " mem_be"},    32'(mem_be), 32'(v.be));
          chk({nm, " mem_wdata"}, mem_wdata, v.data);
          chk({nm, " busy"},      32'(busy), 32'd1);
        end else if (mem_addr !== {v.addr[31:2], 2'b00} || mem_be !== v.be || mem_wdata !== v.data) begin
          stray = 1'b1;
        end
      end
      mem_ready = (v.ready_at != 0 && we_cnt == v.ready_at);
      @(negedge clk);
      mem_ready = 1'b0;
      cyc++;
    end
    chk({nm, " done seen"}, 32'(got), 32'd1);
    chk({nm, " latency"},   32'(cyc), 32'(exp_lat));
    chk({nm, " we cycles"}, 32'(we_cnt), 32'(exp_we));
    chk({nm, " err"},       32'(err), 32'(v.err));
    if (v.err != 2'd1) chk({nm, " ovf"}, 32'(ovf), 32'(v.ovf));
    chk({nm, " we at done"}, 32'({mem_we, busy}), 32'd0);
    chk({nm, " stable/pulses"}, 32'(stray), 32'd0);
  endtask

  initial begin
    vec_t v;
    logic mis;
    int n_done, n_we;
    logic bad;
    logic [31:0] r;

    tbl[0]  = '{32'h100, 2'd2, 32'hDEADBEEF, 1'b0, 3, 4'b1111, 32'hDEADBEEF, 2'd0, 1'b0};
    tbl[1]  = '{32'h203, 2'd0, 32'hFFFFFF80, 1'b1, 1, 4'b1000, 32'h80808080, 2'd0, 1'b0};
    tbl[2]  = '{32'h203, 2'd0, 32'h00000180, 1'b1, 1, 4'b1000, 32'h80808080, 2'd0, 1'b1};
    tbl[3]  = '{32'h302, 2'd1, 32'h0001ABCD, 1'b0, 2, 4'b1100, 32'hABCDABCD, 2'd0, 1'b1};
    tbl[4]  = '{32'h101, 2'd1, 32'h00001234, 1'b0, 1, 4'b0000, 32'h0,        2'd1, 1'b0};
    tbl[5]  = '{32'h102, 2'd2, 32'h12345678, 1'b0, 1, 4'b0000, 32'h0,        2'd1, 1'b0};
    tbl[6]  = '{32'h100, 2'd3, 32'h12345678, 1'b0, 1, 4'b0000, 32'h0,        2'd1, 1'b0};
    tbl[7]  = '{32'h504, 2'd2, 32'hCAFEF00D, 1'b0, 0, 4'b1111, 32'hCAFEF00D, 2'd2, 1'b0};
    tbl[8]  = '{32'h508, 2'd2, 32'h01234567, 1'b1, 4, 4'b1111, 32'h01234567, 2'd0, 1'b0};
    tbl[9]  = '{32'h001, 2'd0, 32'h000000FF, 1'b0, 1, 4'b0010, 32'hFFFFFFFF, 2'd0, 1'b0};
    tbl[10] = '{32'h000, 2'd1, 32'hFFFF8000, 1'b1, 2, 4'b0011, 32'h80008000, 2'd0, 1'b0};
    tbl[11] = '{32'h006, 2'd1, 32'h00008000, 1'b1, 1, 4'b1100, 32'h80008000, 2'd0, 1'b1};

    rst_n = 1'b0; start = 1'b0; addr = 32'd0; wdata = 32'd0; size = 2'd0;
    ext_op = 1'b0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ctrl",  32'({mem_we, busy, done, err, ovf, mem_be}), 32'd0);
    chk("reset addr",  mem_addr, 32'd0);
    chk("reset wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_cmd(tbl[i], $sformatf("vec%0d", i));

    // start held for 10 cycles with memory always ready: accepts only in done cycles
    @(negedge clk);
    addr = 32'h40; size = 2'd0; wdata = 32'h5A; ext_op = 1'b0;
    mem_ready = 1'b1; start = 1'b1;
    n_done = 0; n_we = 0; bad = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) n_done++;
      if (mem_we) n_we++;
      if (done != (i % 2 == 0 && i <= 10)) bad = 1'b1;
      if (mem_we != (i % 2 == 1 && i <= 9)) bad = 1'b1;
      if (i == 10) start = 1'b0;
    end
    mem_ready = 1'b0;
    chk("b2b done count", 32'(n_done), 32'd5);
    chk("b2b we count",   32'(n_we), 32'd5);
    chk("b2b pattern",    32'(bad), 32'd0);

    // asynchronous reset during REQ
    @(negedge clk);
    addr = 32'h400; size = 2'd2; wdata = 32'h87654321; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst mid-req we", 32'(mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async ctrl",  32'({mem_we, busy, done, err, ovf, mem_be}), 32'd0);
    chk("rst async addr",  mem_addr, 32'd0);
    chk("rst async wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done || mem_we) bad = 1'b1;
    end
    chk("no done after rst", 32'(bad), 32'd0);

    // randomized commands against the reference model
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      v.addr = $urandom;
      v.size = 2'($urandom_range(0, 3));
      v.ext  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       v.wdata = r;
        1:       v.wdata = {23'd0, r[8:0]};
        2:       v.wdata = {{23{1'b1}}, r[8:0]};
        default: v.wdata = {{15{r[20]}}, r[16:0]};
      endcase
      v.ready_at = $urandom_range(0, 5);
      model(v.addr, v.size, v.wdata, v.ext, v.be, v.data, mis, v.ovf);
      if (mis) v.err = 2'd1;
      else if (v.ready_at == 0 || v.ready_at > TO) v.err = 2'd2;
      else v.err = 2'd0;
      run_cmd(v, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
